// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM encoding and default qualification time.
// Qualification default is 5 ms at 50 MHz.
package btn_pkg;

    localparam int DB_CYCLES_DEF = 250000;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } db_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, 4-state qualify FSM, registered level and edge pulses.
// Latency DB_CYCLES+3 edges from first sampling edge to btn_stable; no backpressure, pulses are fire-and-forget.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync_q1;
    logic          sync;
    db_state_t     state;
    db_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          stable_nxt;
    logic          press_nxt;
    logic          release_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1       <= 1'b0;
            sync          <= 1'b0;
            state         <= IDLE_LO;
            cnt           <= '0;
            stable        <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q1       <= raw;
            sync          <= sync_q1;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            stable        <= stable_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // Counter defaults to zero so an aborted check never leaves a stale count behind.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE_LO: begin
                if (sync) state_nxt = CHK_HI;
            end
            CHK_HI: begin
                if (!sync) begin
                    state_nxt = IDLE_LO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HI;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            IDLE_HI: begin
                if (!sync) state_nxt = CHK_LO;
            end
            CHK_LO: begin
                if (sync) begin
                    state_nxt = IDLE_HI;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE_LO;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE_LO;
        endcase
        stable_nxt = (state_nxt == IDLE_HI) || (state_nxt == CHK_LO);
    end

endmodule

// File: rtl/btn_debounce.sv
// N_BTN independent debounce channels plus a combined single-cycle change strobe.
// Latency DB_CYCLES+3 edges per channel; no backpressure, outputs are level/pulse only.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_stable,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             changed
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES (DB_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .raw           (btn_raw[i]),
            .stable        (btn_stable[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i])
        );
    end

    // Pulses are registered, so this OR is glitch-free and collapses simultaneous edges into one strobe.
    assign changed = |(btn_press | btn_release);

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DB_CYCLES=8: every level change settles 11 edges later.
module tb_btn_debounce;

    localparam int N_BTN     = 4;
    localparam int DB_CYCLES = 8;
    localparam int ADD_A     = 26;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_stable;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             changed;

    int n_checks = 0;
    int n_errors = 0;

    btn_debounce #(
        .N_BTN     (N_BTN),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_stable  (btn_stable),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .changed     (changed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n edges, requiring the level to hold and no pulses to appear.
    task automatic quiet(input int n, input logic [3:0] stable_exp, input string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            check({tag, "_stable"},  8'(btn_stable),  8'(stable_exp));
            check({tag, "_press"},   8'(btn_press),   8'h00);
            check({tag, "_release"}, 8'(btn_release), 8'h00);
            check({tag, "_changed"}, 8'(changed),     8'h00);
        end
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 4'h0;

        // Scenario 1: reset held 3 cycles, then idle
        tick(); tick(); tick();
        check("rst_stable",  8'(btn_stable),  8'h00);
        check("rst_press",   8'(btn_press),   8'h00);
        check("rst_release", 8'(btn_release), 8'h00);
        check("rst_changed", 8'(changed),     8'h00);
        rst = 1'b0;
        quiet(20, 4'h0, "idle");

        // Scenario 2: press channel 0
        btn_raw = 4'h1;
        quiet(10, 4'h0, "s2_wait");
        tick();
        check("s2_stable",  8'(btn_stable), 8'h01);
        check("s2_press",   8'(btn_press),  8'h01);
        check("s2_changed", 8'(changed),    8'h01);
        check("s2_sum",     8'(ADD_A + int'(btn_stable)), 8'd27);
        tick();
        check("s2_press_end",   8'(btn_press),  8'h00);
        check("s2_changed_end", 8'(changed),    8'h00);
        check("s2_stable_hold", 8'(btn_stable), 8'h01);

        // Scenario 5: release channel 0
        btn_raw = 4'h0;
        quiet(10, 4'h1, "s5_wait");
        tick();
        check("s5_release", 8'(btn_release), 8'h01);
        check("s5_stable",  8'(btn_stable),  8'h00);
        check("s5_changed", 8'(changed),     8'h01);
        tick();
        check("s5_release_end", 8'(btn_release), 8'h00);

        // Scenario 3: bounce on channel 1 shorter than qualification time
        btn_raw = 4'h2;
        repeat (5) tick();
        btn_raw = 4'h0;
        quiet(20, 4'h0, "s3_bounce");

        // Scenario 4: all buttons at once
        btn_raw = 4'hF;
        quiet(10, 4'h0, "s4_wait");
        tick();
        check("s4_stable",  8'(btn_stable), 8'h0F);
        check("s4_press",   8'(btn_press),  8'h0F);
        check("s4_changed", 8'(changed),    8'h01);
        check("s4_sum",     8'(ADD_A + int'(btn_stable)), 8'd41);
        tick();
        check("s4_changed_end", 8'(changed),   8'h00);
        check("s4_press_end",   8'(btn_press), 8'h00);
        btn_raw = 4'h0;
        quiet(10, 4'hF, "s4_rel_wait");
        tick();
        check("s4_release", 8'(btn_release), 8'h0F);
        check("s4_rel_stable", 8'(btn_stable), 8'h00);
        tick();

        // Scenario 6: reset during CHK_HI with button held
        btn_raw = 4'h1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("s6_rst_press",  8'(btn_press),  8'h00);
        check("s6_rst_stable", 8'(btn_stable), 8'h00);
        check("s6_rst_changed", 8'(changed),   8'h00);
        rst = 1'b0;
        quiet(10, 4'h0, "s6_wait");
        tick();
        check("s6_press",  8'(btn_press),  8'h01);
        check("s6_stable", 8'(btn_stable), 8'h01);
        tick();
        check("s6_press_end", 8'(btn_press), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
